fetch_unit: RTL

// - Instruction-fetch stage upstream of field_generator / ctrl_sig_unit in the 16-bit MIPS core.
// - Owns the architectural fetch PC, drives the word-addressed instruction memory (fixed 1-cycle read

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 16-bit MIPS core.
// Owns the fetch PC, issues single-cycle-latency reads to word-addressed
// instruction memory, and buffers returned words in a small FIFO that feeds
// decode over a valid/ready handshake. Redirects flush the FIFO and restart
// fetch; fetch_halt stops new requests while buffered words still drain.
// Optional build macro: FETCH_PERF_CNT_EN adds saturating pop/redirect counters.
module fetch_unit #(
  parameter int              inst_SIZE = 16,
  parameter int              ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic                 imem_rvalid,
  input  logic [inst_SIZE-1:0] imem_rdata,
  output logic                 if_valid,
  input  logic                 if_ready,
  output logic [inst_SIZE-1:0] if_instr,
  output logic [ADDR_W-1:0]    if_pc,
  input  logic                 redirect_valid,
  input  logic [ADDR_W-1:0]    redirect_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]          perf_fetch_cnt,
  output logic [15:0]          perf_flush_cnt,
`endif
  input  logic                 fetch_halt
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FQ_DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HALT} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      pc_fetch;
  logic [ADDR_W-1:0]      tag_pc_p1;
  logic                   inflight_p1;
  logic [inst_SIZE-1:0]   q_instr [FQ_DEPTH];
  logic [ADDR_W-1:0]      q_pc    [FQ_DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W:0]         credit;
  logic                   issue, pop, push, kill;

  // Occupancy the queue will reach if everything outstanding lands and the
  // current pop retires; a new request is only allowed below the depth.
  assign credit = {1'b0, count} + {{CNT_W{1'b0}}, inflight_p1} - {{CNT_W{1'b0}}, pop};

  assign if_valid  = (count != '0);
  assign pop       = if_valid & if_ready;
  assign kill      = redirect_valid;
  assign push      = imem_rvalid & inflight_p1 & ~kill;
  assign if_instr  = if_valid ? q_instr[rd_ptr] : '0;
  assign if_pc     = if_valid ? q_pc[rd_ptr]    : '0;
  assign imem_req  = issue;
  assign imem_addr = pc_fetch;

  // Next-state and request decision
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      S_BOOT:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (fetch_halt) state_nxt = S_HALT;
        else            issue     = ~redirect_valid & (credit < DEPTH_C);
      end
      S_HALT:  if (!fetch_halt) state_nxt = S_FETCH;
      default: state_nxt = S_BOOT;
    endcase
  end

  // FSM state, fetch PC and in-flight flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_BOOT;
      pc_fetch    <= RESET_PC;
      inflight_p1 <= 1'b0;
    end else begin
      state       <= state_nxt;
      inflight_p1 <= issue;
      if (redirect_valid) pc_fetch <= redirect_pc;
      else if (issue)     pc_fetch <= pc_fetch + ADDR_W'(1);
    end
  end

  // Request address tag, paired with the response one cycle later
  always_ff @(posedge clk) begin
    if (issue) tag_pc_p1 <= pc_fetch;
  end

  // Queue pointers and occupancy; a redirect empties the queue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Queue storage written on accepted responses
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= tag_pc_p1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  // Saturating event counters: delivered instructions and redirect cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pop)            perf_fetch_cnt <= sat_inc32(perf_fetch_cnt);
      if (redirect_valid) perf_flush_cnt <= sat_inc16(perf_flush_cnt);
    end
  end
`endif

endmodule
